// File: rtl/hangman_pkg.sv
// Shared types and defaults for the hangman round controller.
package hangman_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WON  = 2'd2,
    LOST = 2'd3
  } state_t;

  localparam int DEF_N_SYMBOLS = 26;
  localparam int DEF_MAX_LIVES = 6;
  localparam int LIVES_W       = 4;
endpackage

// File: rtl/hangman_lives_ctr.sv
// Lives counter: load to MAX_LIVES, saturating decrement, registered count.
// zero_next flags that this cycle's decrement leaves no lives.
module hangman_lives_ctr
  import hangman_pkg::*;
#(
  parameter int MAX_LIVES = DEF_MAX_LIVES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               dec,
  output logic [LIVES_W-1:0] lives,
  output logic               zero_next
);
  localparam logic [LIVES_W-1:0] INIT = LIVES_W'(MAX_LIVES);

  always_ff @(posedge clk) begin
    if (reset || load) begin
      lives <= INIT;
    end else if (dec && lives != '0) begin
      lives <= lives - 1'b1;
    end
  end

  assign zero_next = dec && (lives <= LIVES_W'(1));
endmodule

// File: rtl/hangman_round.sv
// Hangman round FSM: results registered one cycle after an accepted guess.
// Optional HANGMAN_REPEAT_PENALTY_EN makes repeat guesses cost a life.
module hangman_round
  import hangman_pkg::*;
#(
  parameter int N_SYMBOLS = DEF_N_SYMBOLS,
  parameter int MAX_LIVES = DEF_MAX_LIVES,
  parameter int IDX_W     = $clog2(N_SYMBOLS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [N_SYMBOLS-1:0] secret,
  input  logic                 guess_valid,
  input  logic [IDX_W-1:0]     guess_idx,
  output logic                 guess_ready,
  output logic [N_SYMBOLS-1:0] guessed,
  output logic [LIVES_W-1:0]   lives_left,
  output logic                 hit,
  output logic                 miss,
  output logic                 repeated,
  output logic                 invalid,
  output logic [1:0]           state
);
  state_t               st;
  logic [N_SYMBOLS-1:0] secret_reg;
  logic [N_SYMBOLS-1:0] onehot;
  logic [N_SYMBOLS-1:0] guessed_next;
  logic                 accept;
  logic                 idx_ok;
  logic                 is_rep;
  logic                 is_hit;
  logic                 won;
  logic                 cost;
  logic                 dec;
  logic                 zero_next;

  assign guess_ready = (st == PLAY);
  assign state       = st;

  // A start in the same cycle as a guess wins; the guess is dropped.
  assign accept = guess_valid && guess_ready && !start;
  assign idx_ok = int'(guess_idx) < N_SYMBOLS;

  // Out-of-range indices shift the bit off the top, so onehot is zero then.
  assign onehot       = {{(N_SYMBOLS-1){1'b0}}, 1'b1} << guess_idx;
  assign is_rep       = |(guessed & onehot);
  assign is_hit       = |(secret_reg & onehot);
  assign guessed_next = guessed | onehot;
  assign won          = ((guessed_next & secret_reg) == secret_reg);

`ifdef HANGMAN_REPEAT_PENALTY_EN
  assign cost = is_rep || !is_hit;
`else
  assign cost = !is_rep && !is_hit;
`endif
  assign dec = accept && idx_ok && cost;

  hangman_lives_ctr #(
    .MAX_LIVES(MAX_LIVES)
  ) u_lives (
    .clk      (clk),
    .reset    (reset),
    .load     (start),
    .dec      (dec),
    .lives    (lives_left),
    .zero_next(zero_next)
  );

  always_ff @(posedge clk) begin
    hit      <= 1'b0;
    miss     <= 1'b0;
    repeated <= 1'b0;
    invalid  <= 1'b0;
    if (reset) begin
      st         <= IDLE;
      guessed    <= '0;
      secret_reg <= '0;
    end else if (start) begin
      guessed    <= '0;
      secret_reg <= secret;
      st         <= (secret == '0) ? WON : PLAY;
    end else if (accept) begin
      if (!idx_ok) begin
        invalid <= 1'b1;
      end else if (is_rep) begin
        repeated <= 1'b1;
        if (zero_next) st <= LOST;
      end else begin
        guessed <= guessed_next;
        if (is_hit) begin
          hit <= 1'b1;
          if (won) st <= WON;
        end else begin
          miss <= 1'b1;
          if (zero_next) st <= LOST;
        end
      end
    end
  end
endmodule

// File: tb/tb_hangman_round.sv
// Scoreboard bench for hangman_round: a reference model queues expected results per cycle.
module tb_hangman_round;
  localparam int N  = 26;
  localparam int ML = 6;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          reset, start, guess_valid;
  logic [N-1:0]  secret;
  logic [IW-1:0] guess_idx;
  logic          guess_ready, hit, miss, repeated, invalid;
  logic [N-1:0]  guessed;
  logic [3:0]    lives_left;
  logic [1:0]    state;

  always #5 clk = ~clk;

  hangman_round #(.N_SYMBOLS(N), .MAX_LIVES(ML), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .start(start), .secret(secret),
    .guess_valid(guess_valid), .guess_idx(guess_idx), .guess_ready(guess_ready),
    .guessed(guessed), .lives_left(lives_left), .hit(hit), .miss(miss),
    .repeated(repeated), .invalid(invalid), .state(state)
  );

  typedef struct packed {
    logic       hit, miss, rep, inv;
    logic [3:0] lives;
    logic [1:0] st;
    logic [N-1:0] g;
  } res_t;

  res_t sb[$];
  int checks = 0;
  int errors = 0;

  logic [1:0]   m_state;
  logic [3:0]   m_lives;
  logic [N-1:0] m_guessed, m_secret;

  function automatic res_t observed();
    return {hit, miss, repeated, invalid, lives_left, state, guessed};
  endfunction

  // Drive one cycle of stimulus, advance the model, queue its expected outcome.
  task automatic step(input logic rs, input logic st, input logic [N-1:0] sec,
                      input logic gv, input logic [IW-1:0] gi);
    res_t e;
    logic [N-1:0] mask;
    @(negedge clk);
    reset = rs; start = st; secret = sec; guess_valid = gv; guess_idx = gi;
    e = '0;
    mask = N'(1) << gi;
    if (rs) begin
      m_state = 2'd0; m_lives = 4'(ML); m_guessed = '0; m_secret = '0;
    end else if (st) begin
      m_guessed = '0; m_lives = 4'(ML); m_secret = sec;
      m_state = (sec == '0) ? 2'd2 : 2'd1;
    end else if (gv && m_state == 2'd1) begin
      if (int'(gi) >= N) begin
        e.inv = 1'b1;
      end else if ((m_guessed & mask) != '0) begin
        e.rep = 1'b1;
`ifdef HANGMAN_REPEAT_PENALTY_EN
        m_lives = m_lives - 4'd1;
        if (m_lives == 4'd0) m_state = 2'd3;
`endif
      end else begin
        m_guessed = m_guessed | mask;
        if ((m_secret & mask) != '0) begin
          e.hit = 1'b1;
          if ((m_guessed & m_secret) == m_secret) m_state = 2'd2;
        end else begin
          e.miss = 1'b1;
          m_lives = m_lives - 4'd1;
          if (m_lives == 4'd0) m_state = 2'd3;
        end
      end
    end
    e.lives = m_lives; e.st = m_state; e.g = m_guessed;
    sb.push_back(e);
    @(posedge clk);
    #1;
    reset = 1'b0; start = 1'b0; guess_valid = 1'b0;
  endtask

  task automatic test_reset();
    res_t got, exp;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) step(1'b1, 1'b0, '0, 1'b1, 5'd3);
      else       step(1'b0, 1'b0, '0, 1'b1, 5'd3);
      got = observed(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL reset step %0d: got %h want %h", i, got, exp); end
    end
    checks++;
    if (guess_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", guess_ready); end
  endtask

  task automatic test_win();
    res_t got, exp;
    logic [IW-1:0] seq [2] = '{5'd0, 5'd4};
    step(1'b0, 1'b1, N'(26'h11), 1'b0, '0);
    got = observed(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL win start: got %h want %h", got, exp); end
    checks++;
    if (guess_ready !== 1'b1) begin errors++; $display("FAIL win_ready: got %b want 1", guess_ready); end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, '0, 1'b1, seq[i]);
      got = observed(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL win guess %0d: got %h want %h", i, got, exp); end
    end
    checks++;
    if (state !== 2'd2 || lives_left !== 4'd6 || hit !== 1'b1) begin
      errors++; $display("FAIL win_final: state %0d lives %0d hit %b want 2 6 1", state, lives_left, hit);
    end
  endtask

  task automatic test_loss();
    res_t got, exp;
    step(1'b0, 1'b1, N'(1), 1'b0, '0);
    void'(sb.pop_front());
    for (int i = 1; i <= 7; i++) begin
      step(1'b0, 1'b0, '0, 1'b1, IW'(i));
      got = observed(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL loss guess %0d: got %h want %h", i, got, exp); end
      if (i == 6) begin
        checks++;
        if (miss !== 1'b1 || lives_left !== 4'd0 || state !== 2'd3) begin
          errors++; $display("FAIL loss_sixth: miss %b lives %0d state %0d want 1 0 3", miss, lives_left, state);
        end
      end
    end
  endtask

  task automatic test_repeat();
    res_t got, exp;
    logic [3:0] want_lives;
`ifdef HANGMAN_REPEAT_PENALTY_EN
    want_lives = 4'd4;
`else
    want_lives = 4'd5;
`endif
    step(1'b0, 1'b1, N'(1), 1'b0, '0);
    void'(sb.pop_front());
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, '0, 1'b1, 5'd2);
      got = observed(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL repeat guess %0d: got %h want %h", i, got, exp); end
    end
    checks++;
    if (repeated !== 1'b1 || lives_left !== want_lives) begin
      errors++; $display("FAIL repeat_lives: rep %b lives %0d want 1 %0d", repeated, lives_left, want_lives);
    end
  endtask

  task automatic test_invalid();
    res_t got, exp;
    logic [IW-1:0] seq [3] = '{5'd27, 5'd26, 5'd25};
    step(1'b0, 1'b1, N'(1), 1'b0, '0);
    void'(sb.pop_front());
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, '0, 1'b1, seq[i]);
      got = observed(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL invalid guess %0d: got %h want %h", i, got, exp); end
      if (i == 0) begin
        checks++;
        if (invalid !== 1'b1 || guessed !== '0 || lives_left !== 4'd6) begin
          errors++; $display("FAIL invalid_27: inv %b guessed %h lives %0d want 1 0 6", invalid, guessed, lives_left);
        end
      end
    end
  endtask

  task automatic test_restart_reset();
    res_t got, exp;
    step(1'b0, 1'b1, N'(1), 1'b0, '0);
    void'(sb.pop_front());
    for (int i = 0; i < 5; i++) begin
      case (i)
        0:       step(1'b0, 1'b0, '0, 1'b1, 5'd1);
        1:       step(1'b0, 1'b0, '0, 1'b1, 5'd2);
        2:       step(1'b0, 1'b1, N'(26'h8), 1'b1, 5'd5);
        3:       step(1'b0, 1'b0, '0, 1'b1, 5'd4);
        default: step(1'b1, 1'b0, '0, 1'b1, 5'd3);
      endcase
      got = observed(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL restart step %0d: got %h want %h", i, got, exp); end
      if (i == 2) begin
        checks++;
        if (guessed !== '0 || lives_left !== 4'd6 || state !== 2'd1 || miss !== 1'b0) begin
          errors++; $display("FAIL restart_clear: guessed %h lives %0d state %0d miss %b want 0 6 1 0",
                             guessed, lives_left, state, miss);
        end
      end
    end
    checks++;
    if (state !== 2'd0 || {hit, miss, repeated, invalid} !== 4'b0 || lives_left !== 4'd6) begin
      errors++; $display("FAIL reset_mid: state %0d pulses %b lives %0d want 0 0000 6",
                         state, {hit, miss, repeated, invalid}, lives_left);
    end
  endtask

  task automatic test_empty();
    res_t got, exp;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) step(1'b0, 1'b1, '0, 1'b0, '0);
      else        step(1'b0, 1'b0, '0, 1'b1, 5'd0);
      got = observed(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL empty step %0d: got %h want %h", i, got, exp); end
    end
    checks++;
    if (state !== 2'd2 || guess_ready !== 1'b0) begin
      errors++; $display("FAIL empty_won: state %0d ready %b want 2 0", state, guess_ready);
    end
  endtask

  task automatic test_back_to_back();
    res_t got, exp;
    logic [IW-1:0] seq [6] = '{5'd1, 5'd2, 5'd31, 5'd2, 5'd9, 5'd3};
    step(1'b0, 1'b1, N'(26'hE), 1'b0, '0);
    void'(sb.pop_front());
    for (int i = 0; i < 7; i++) begin
      if (i == 3) step(1'b0, 1'b0, '0, 1'b0, 5'd7);
      else        step(1'b0, 1'b0, '0, 1'b1, seq[(i > 3) ? i - 1 : i]);
      got = observed(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL b2b step %0d: got %h want %h", i, got, exp); end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; secret = '0; guess_valid = 1'b0; guess_idx = '0;
    m_state = 2'd0; m_lives = 4'(ML); m_guessed = '0; m_secret = '0;
    test_reset();
    test_win();
    test_loss();
    test_repeat();
    test_invalid();
    test_restart_reset();
    test_empty();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hangman_round.md
HANGMAN_ROUND -- requirements
Module: hangman_round

Interface
REQ-001 Parameter N_SYMBOLS, default 26, alphabet size (number of guessable symbols).
REQ-002 Parameter MAX_LIVES, default 6, wrong guesses allowed before loss; range 1..15.
REQ-003 Parameter IDX_W, default $clog2(N_SYMBOLS), guess index width.
REQ-004 clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  begin a new round; secret latched this cycle.
REQ-006 secret  in  N_SYMBOLS  bit i=1 means symbol i occurs in the word.
REQ-007 guess_valid  in  1  guess offered; guess_idx  in  IDX_W  symbol index.
REQ-008 guess_ready  out  1  high only in PLAY.
REQ-009 guessed  out  N_SYMBOLS  symbols guessed so far this round.
REQ-010 lives_left  out  4  remaining lives.
REQ-011 hit, miss, repeat, invalid  out  1 each  one-cycle result pulses.
REQ-012 state  out  2  IDLE=0, PLAY=1, WON=2, LOST=3.

Function
REQ-013 A guess is accepted when guess_valid && guess_ready; all result outputs are registered and appear on the cycle after acceptance.
REQ-014 At most one result pulse is set per accepted guess; all pulses are low in cycles with no accepted guess.
REQ-015 guess_idx >= N_SYMBOLS: invalid pulse; guessed and lives_left unchanged.
REQ-016 guessed[idx] already 1: repeat pulse; guessed unchanged; lives unchanged unless REQ-028 applies.
REQ-017 New idx with secret bit 1: set guessed[idx], hit pulse.
REQ-018 New idx with secret bit 0: set guessed[idx], miss pulse, lives_left decrements by 1.
REQ-019 The win check includes the current guess: if (guessed_next & secret_reg) == secret_reg, state becomes WON in the same cycle that hit pulses.
REQ-020 If lives_left reaches 0 on a miss, state becomes LOST in the same cycle that miss pulses; lives_left never underflows.
REQ-021 FSM: IDLE -start-> PLAY; PLAY -win-> WON; PLAY -lives 0-> LOST; WON/LOST -start-> PLAY.
REQ-022 start in any state, including PLAY: clear guessed, load lives_left=MAX_LIVES, latch secret, enter PLAY next cycle; any guess offered in that cycle is ignored.
REQ-023 start with secret all-zero: latch it, then enter WON next cycle with no pulses.
REQ-024 In WON/LOST, guessed and lives_left hold their final values and guess_valid is ignored.

Reset
REQ-025 reset has priority over start and guesses.
REQ-026 Reset values: state=IDLE, guessed=0, lives_left=MAX_LIVES, all pulses 0, guess_ready=0, internal secret register 0.
REQ-027 Reset asserted mid-round discards the round entirely; no pulse is emitted for a guess offered in the reset cycle.

Configuration
REQ-028 With macro HANGMAN_REPEAT_PENALTY_EN defined, a repeat guess also decrements lives_left and can cause LOST per REQ-020. Without it, repeats never cost a life.

Structure
REQ-029 Package hangman_pkg holds the state enum, the default N_SYMBOLS and MAX_LIVES, and the lives width constant (4).
REQ-030 One sub-module, hangman_lives_ctr, implements the lives counter: load, saturating decrement and zero flag. Everything else stays in hangman_round.

Verification
REQ-031 Win: secret = bits{0,4}, start, guess 0 then 4 -> hit, hit; state=WON after the second hit; lives_left=6.
REQ-032 Loss: secret = bit 0, MAX_LIVES=6, guess 1..6 -> six miss pulses; lives_left 5..0; state=LOST with the sixth miss; a seventh guess is ignored.
REQ-033 Repeat: guess 2 twice with secret bit 2 = 0 -> miss then repeat; lives_left=5; with HANGMAN_REPEAT_PENALTY_EN, lives_left=4.
REQ-034 Invalid: guess_idx=27 with N_SYMBOLS=26 -> invalid pulse; guessed and lives_left unchanged.
REQ-035 Restart and reset: start mid-round after 2 misses -> guessed=0, lives_left=6, PLAY; reset during a guess -> IDLE, no pulse.
REQ-036 Empty secret: start with secret=0 -> WON next cycle with no pulses.
